mem_stage_ctrl: RTL and testbench

- Data-memory access controller for the MEM stage of the 5-stage pipeline CPU.
- Sits between the EX/MEM pipeline register (upstream) and the MEM/WB pipeline register (downstream).
- Converts MemRead/MemWrite requests into a req/ack handshake with a variable-latency data memory.
- Stalls the pipeline until the access completes, then presents load data for the MEM/WB register to capture.

---
 rtl/mem_stage_ctrl.sv | 114 +++++++++++
 tb/tb_mem_stage_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
// ============================================================================
// Module   : mem_stage_ctrl
// Purpose  : MEM-stage data-memory controller that turns pipeline load/store
//            requests into a req/ack handshake and stalls until completion.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] ALUResult_i,
    input  logic [31:0] RS2data_i,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [31:0] ReadData_o,
    output logic        stall_o,
    output logic        err_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_LAST_WAIT = CNT_W'(TIMEOUT - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;

    logic w_access;
    logic w_misalign;
    logic w_is_read;

    assign w_access   = MemRead_i | MemWrite_i;
    assign w_misalign = (ALUResult_i[1:0] != 2'b00);
    // A simultaneous read+write request is treated as a write.
    assign w_is_read  = MemRead_i & ~MemWrite_i;

    assign stall_o = ((r_state == IDLE) & w_access & ~w_misalign) | (r_state == REQ);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            ReadData_o  <= '0;
            err_o       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_access) begin
                        if (w_misalign) begin
                            err_o <= 1'b1;
                            if (w_is_read) begin
                                ReadData_o <= '0;
                            end
                        end else begin
                            mem_addr_o  <= ALUResult_i;
                            mem_wdata_o <= RS2data_i;
                            mem_we_o    <= MemWrite_i;
                            mem_req_o   <= 1'b1;
                            r_cnt       <= '0;
                            r_state     <= REQ;
                        end
                    end
                end

                REQ: begin
                    if (mem_ack_i) begin
                        mem_req_o <= 1'b0;
                        if (!mem_we_o) begin
                            ReadData_o <= mem_rdata_i;
                        end
                        r_state <= DONE;
                    end else if (r_cnt == c_LAST_WAIT) begin
                        mem_req_o  <= 1'b0;
                        err_o      <= 1'b1;
                        ReadData_o <= '0;
                        r_state    <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                // One-cycle gap so the instruction still in EX/MEM is not re-issued.
                DONE: begin
                    r_state <= IDLE;
                end

                default: begin
                    r_state   <= IDLE;
                    mem_req_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage_ctrl.sv
// ============================================================================
// Module   : tb_mem_stage_ctrl
// Purpose  : Self-checking bench for mem_stage_ctrl against a transaction model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_stage_ctrl;

    localparam int TO = 16;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        MemRead_i, MemWrite_i;
    logic [31:0] ALUResult_i, RS2data_i;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o, ReadData_o;
    logic        stall_o, err_o;

    int total = 0;
    int bad   = 0;

    logic        exp_err;
    logic [31:0] exp_rdata;

    mem_stage_ctrl #(.TIMEOUT(TO), .CNT_W(5)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .MemRead_i   (MemRead_i),
        .MemWrite_i  (MemWrite_i),
        .ALUResult_i (ALUResult_i),
        .RS2data_i   (RS2data_i),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .ReadData_o  (ReadData_o),
        .stall_o     (stall_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // One pipeline instruction held in EX/MEM until the stall releases.
    // lat = number of REQ cycles without ack before the ack cycle.
    task automatic do_instr(input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input int lat, input logic [31:0] rdata);
        int   req_cyc   = 0;
        int   stall_cyc = 0;
        int   n         = 0;
        bit   done      = 0;
        int   exp_req;
        int   exp_stall;
        logic access;
        logic mis;

        MemRead_i   = rd;
        MemWrite_i  = wr;
        ALUResult_i = addr;
        RS2data_i   = wdata;
        access      = rd | wr;
        mis         = (addr[1:0] != 2'b00);

        while (!done) begin
            @(negedge clk_i);
            if (mem_req_o) begin
                req_cyc++;
                chk("addr_hold", mem_addr_o, addr);
                chk("we_hold", {31'd0, mem_we_o}, {31'd0, wr});
                chk("wdata_hold", mem_wdata_o, wdata);
                mem_ack_i   = (req_cyc == lat + 1);
                mem_rdata_i = mem_ack_i ? rdata : $urandom;
            end else begin
                // Stray acks outside a request must be ignored.
                mem_ack_i   = 1'($urandom_range(0, 1));
                mem_rdata_i = $urandom;
            end
            if (stall_o) stall_cyc++;
            else         done = 1;
            n++;
            if (!done && n > 100) begin
                chk("hang_stall", {31'd0, stall_o}, 32'd0);
                done = 1;
            end
        end
        @(posedge clk_i);
        #1;
        mem_ack_i = 1'b0;

        if (!access || mis) exp_req = 0;
        else if (lat + 1 <= TO) exp_req = lat + 1;
        else exp_req = TO;
        exp_stall = (exp_req == 0) ? 0 : exp_req + 1;

        if (access) begin
            if (mis) begin
                exp_err = 1'b1;
                if (!wr) exp_rdata = 32'd0;
            end else if (lat + 1 <= TO) begin
                if (!wr) exp_rdata = rdata;
            end else begin
                exp_err   = 1'b1;
                exp_rdata = 32'd0;
            end
        end

        chk("req_cycles", 32'(req_cyc), 32'(exp_req));
        chk("stall_cycles", 32'(stall_cyc), 32'(exp_stall));
        chk("ReadData", ReadData_o, exp_rdata);
        chk("err", {31'd0, err_o}, {31'd0, exp_err});
    endtask

    initial begin
        logic        rd, wr;
        logic [31:0] a;
        int          lat;

        rst_i       = 1'b0;
        MemRead_i   = 1'b0;
        MemWrite_i  = 1'b0;
        ALUResult_i = 32'd0;
        RS2data_i   = 32'd0;
        mem_ack_i   = 1'b0;
        mem_rdata_i = 32'd0;
        exp_err     = 1'b0;
        exp_rdata   = 32'd0;

        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_req", {31'd0, mem_req_o}, 32'd0);
        chk("rst_we", {31'd0, mem_we_o}, 32'd0);
        chk("rst_addr", mem_addr_o, 32'd0);
        chk("rst_wdata", mem_wdata_o, 32'd0);
        chk("rst_rdata", ReadData_o, 32'd0);
        chk("rst_err", {31'd0, err_o}, 32'd0);
        chk("rst_stall", {31'd0, stall_o}, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;

        // Directed cases
        do_instr(1'b1, 1'b0, 32'h100, 32'h0, 0, 32'hCAFEBABE);
        do_instr(1'b0, 1'b1, 32'h204, 32'h12345678, 3, 32'h0);
        do_instr(1'b0, 1'b0, 32'h300, 32'h0, 0, 32'h0);
        do_instr(1'b1, 1'b1, 32'h208, 32'hA5A5A5A5, 1, 32'h0);
        do_instr(1'b1, 1'b0, 32'h40, 32'h0, TO - 1, 32'h0BADF00D);
        do_instr(1'b1, 1'b0, 32'h44, 32'h0, 0, 32'h11112222);
        do_instr(1'b1, 1'b0, 32'h40, 32'h0, 1000, 32'h0);
        do_instr(1'b1, 1'b0, 32'h48, 32'h0, 2, 32'h33334444);
        do_instr(1'b1, 1'b0, 32'h102, 32'h0, 0, 32'h0);

        // Reset in the middle of a request
        MemRead_i   = 1'b1;
        MemWrite_i  = 1'b0;
        ALUResult_i = 32'h80;
        mem_ack_i   = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("mid_req_high", {31'd0, mem_req_o}, 32'd1);
        MemRead_i = 1'b0;
        rst_i     = 1'b0;
        #1;
        chk("mid_rst_req", {31'd0, mem_req_o}, 32'd0);
        chk("mid_rst_err", {31'd0, err_o}, 32'd0);
        chk("mid_rst_rdata", ReadData_o, 32'd0);
        chk("mid_rst_stall", {31'd0, stall_o}, 32'd0);
        exp_err   = 1'b0;
        exp_rdata = 32'd0;
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        do_instr(1'b1, 1'b0, 32'h84, 32'h0, 0, 32'h55667788);

        // Randomized instruction stream
        for (int i = 0; i < 150; i++) begin
            rd  = 1'($urandom_range(0, 1));
            wr  = 1'($urandom_range(0, 1));
            a   = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            lat = ($urandom_range(0, 9) == 0) ? TO + 3 : int'($urandom_range(0, 5));
            if ($urandom_range(0, 19) == 0) lat = TO - 1;
            do_instr(rd, wr, a, $urandom, lat, $urandom);
        end

        MemRead_i  = 1'b0;
        MemWrite_i = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
